pingpong_lane_ram: RTL and testbench

- Dual-bank (ping-pong) complex-sample RAM for the FFT datapath.
- The FFT engine owns one bank while the IO side loads/unloads the other. Bank ownership swaps under a req/ack handshake.
- Generalises the fixed two-port arbitrated RAM to LANES parallel read/write lanes per side, with registered read-valid tracking and a swap state machine.

---
 rtl/pingpong_lane_ram_pkg.sv | 22 ++
 rtl/pingpong_bank.sv | 66 ++++++
 rtl/pingpong_lane_ram.sv | 116 +++++++++++
 tb/tb_pingpong_lane_ram.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pingpong_lane_ram_pkg.sv
// Shared definitions for the ping-pong lane RAM: swap FSM encoding and lane slicing helpers.
// No logic; constants and constant functions only.
// Used by pingpong_bank and pingpong_lane_ram via import pingpong_lane_ram_pkg::*.
package pingpong_lane_ram_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_SWAP  = 2'd2
    } state_t;

    // A complex sample is a real part followed by an imaginary part.
    function automatic int sample_w(input int word_size);
        return 2 * word_size;
    endfunction

    // Low bit of lane 'lane' in a flattened bus of 'width'-bit lane fields.
    function automatic int lane_lo(input int lane, input int width);
        return lane * width;
    endfunction

endpackage

// File: rtl/pingpong_bank.sv
// One N-deep sample bank with LANES write and LANES read lanes; highest write lane wins on collision.
// Read latency 1 cycle (registered data and valid); writes commit at the clock edge.
// No backpressure; optional RAM_BYPASS_EN forwards same-cycle writes to reads (new-data semantics).
module pingpong_bank
    import pingpong_lane_ram_pkg::*;
#(
    parameter int N         = 32,
    parameter int WORD_SIZE = 16,
    parameter int LANES     = 2,
    parameter int ADDR_W    = $clog2(N)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [LANES-1:0]              wr_en,
    input  logic [LANES*ADDR_W-1:0]       wr_addr,
    input  logic [LANES*2*WORD_SIZE-1:0]  wr_data,
    input  logic [LANES-1:0]              rd_en,
    input  logic [LANES*ADDR_W-1:0]       rd_addr,
    output logic [LANES*2*WORD_SIZE-1:0]  rd_data,
    output logic [LANES-1:0]              rd_valid
);

    localparam int SW = sample_w(WORD_SIZE);

    logic [SW-1:0]          mem [N];
    logic [LANES*SW-1:0]    rd_next;

    // Commit writes in ascending lane order so the highest-index lane wins a shared address.
    always_ff @(posedge clk) begin
        for (int k = 0; k < LANES; k++) begin
            if (wr_en[k]) begin
                mem[wr_addr[lane_lo(k, ADDR_W) +: ADDR_W]] <= wr_data[lane_lo(k, SW) +: SW];
            end
        end
    end

    // Next read data per lane: old contents, optionally overridden by a same-cycle write.
    always_comb begin
        rd_next = rd_data;
        for (int k = 0; k < LANES; k++) begin
            if (rd_en[k]) begin
                rd_next[lane_lo(k, SW) +: SW] = mem[rd_addr[lane_lo(k, ADDR_W) +: ADDR_W]];
`ifdef RAM_BYPASS_EN
                for (int j = 0; j < LANES; j++) begin
                    if (wr_en[j] &&
                        wr_addr[lane_lo(j, ADDR_W) +: ADDR_W] == rd_addr[lane_lo(k, ADDR_W) +: ADDR_W]) begin
                        rd_next[lane_lo(k, SW) +: SW] = wr_data[lane_lo(j, SW) +: SW];
                    end
                end
`endif
            end
        end
    end

    // Register read data (held between reads) and a one-cycle valid per accepted read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data  <= '0;
            rd_valid <= '0;
        end else begin
            rd_data  <= rd_next;
            rd_valid <= rd_en;
        end
    end

endmodule

// File: rtl/pingpong_lane_ram.sv
// Dual-bank ping-pong sample RAM: FFT side owns bank fft_bank, IO side the other; swap via req/ack FSM.
// Read latency 1 cycle; swap_req at cycle t gives swap_ack (with new fft_bank) at t+3.
// No backpressure; all enables are dropped while busy (DRAIN/SWAP). Optional macro: RAM_BYPASS_EN.
module pingpong_lane_ram
    import pingpong_lane_ram_pkg::*;
#(
    parameter int N         = 32,
    parameter int WORD_SIZE = 16,
    parameter int LANES     = 2,
    parameter int ADDR_W    = $clog2(N)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          swap_req,
    output logic                          swap_ack,
    output logic                          busy,
    output logic                          fft_bank,
    input  logic [LANES-1:0]              io_wr_en,
    input  logic [LANES*ADDR_W-1:0]       io_wr_addr,
    input  logic [LANES*2*WORD_SIZE-1:0]  io_wr_data,
    input  logic [LANES-1:0]              io_rd_en,
    input  logic [LANES*ADDR_W-1:0]       io_rd_addr,
    output logic [LANES*2*WORD_SIZE-1:0]  io_rd_data,
    output logic [LANES-1:0]              io_rd_valid,
    input  logic [LANES-1:0]              fft_wr_en,
    input  logic [LANES*ADDR_W-1:0]       fft_wr_addr,
    input  logic [LANES*2*WORD_SIZE-1:0]  fft_wr_data,
    input  logic [LANES-1:0]              fft_rd_en,
    input  logic [LANES*ADDR_W-1:0]       fft_rd_addr,
    output logic [LANES*2*WORD_SIZE-1:0]  fft_rd_data,
    output logic [LANES-1:0]              fft_rd_valid
);

    localparam int SW = sample_w(WORD_SIZE);

    state_t state, state_nxt;
    logic   run;

    logic [LANES-1:0] io_wr_g, io_rd_g, fft_wr_g, fft_rd_g;

    logic [LANES-1:0]        b_wr_en    [2];
    logic [LANES*ADDR_W-1:0] b_wr_addr  [2];
    logic [LANES*SW-1:0]     b_wr_data  [2];
    logic [LANES-1:0]        b_rd_en    [2];
    logic [LANES*ADDR_W-1:0] b_rd_addr  [2];
    logic [LANES*SW-1:0]     b_rd_data  [2];
    logic [LANES-1:0]        b_rd_valid [2];

    // Swap sequencing: one DRAIN cycle for the last read to land, one SWAP cycle to flip ownership.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN:   if (swap_req) state_nxt = ST_DRAIN;
            ST_DRAIN: state_nxt = ST_SWAP;
            ST_SWAP:  state_nxt = ST_RUN;
            default:  state_nxt = ST_RUN;
        endcase
    end

    // State, bank ownership, and the ack pulse that coincides with the new ownership.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_RUN;
            fft_bank <= 1'b0;
            swap_ack <= 1'b0;
        end else begin
            state    <= state_nxt;
            swap_ack <= (state == ST_SWAP);
            if (state == ST_SWAP) begin
                fft_bank <= ~fft_bank;
            end
        end
    end

    assign run  = (state == ST_RUN);
    assign busy = ~run;

    // Accesses only count in RUN, so ownership can never change under an in-flight access.
    assign io_wr_g  = io_wr_en  & {LANES{run}};
    assign io_rd_g  = io_rd_en  & {LANES{run}};
    assign fft_wr_g = fft_wr_en & {LANES{run}};
    assign fft_rd_g = fft_rd_en & {LANES{run}};

    for (genvar b = 0; b < 2; b++) begin : g_bank
        logic to_fft;
        assign to_fft       = (fft_bank == 1'(b));
        assign b_wr_en[b]   = to_fft ? fft_wr_g    : io_wr_g;
        assign b_wr_addr[b] = to_fft ? fft_wr_addr : io_wr_addr;
        assign b_wr_data[b] = to_fft ? fft_wr_data : io_wr_data;
        assign b_rd_en[b]   = to_fft ? fft_rd_g    : io_rd_g;
        assign b_rd_addr[b] = to_fft ? fft_rd_addr : io_rd_addr;

        pingpong_bank #(
            .N         (N),
            .WORD_SIZE (WORD_SIZE),
            .LANES     (LANES),
            .ADDR_W    (ADDR_W)
        ) u_bank (
            .clk      (clk),
            .reset    (reset),
            .wr_en    (b_wr_en[b]),
            .wr_addr  (b_wr_addr[b]),
            .wr_data  (b_wr_data[b]),
            .rd_en    (b_rd_en[b]),
            .rd_addr  (b_rd_addr[b]),
            .rd_data  (b_rd_data[b]),
            .rd_valid (b_rd_valid[b])
        );
    end

    assign fft_rd_data  = fft_bank ? b_rd_data[1]  : b_rd_data[0];
    assign fft_rd_valid = fft_bank ? b_rd_valid[1] : b_rd_valid[0];
    assign io_rd_data   = fft_bank ? b_rd_data[0]  : b_rd_data[1];
    assign io_rd_valid  = fft_bank ? b_rd_valid[0] : b_rd_valid[1];

endmodule

// File: tb/tb_pingpong_lane_ram.sv
// Self-checking bench for pingpong_lane_ram: directed steps plus random traffic against a bank-array model.
// Reads are checked one cycle after issue; swap timing and reset-during-swap are checked directly.
// Honours RAM_BYPASS_EN in the model so either build can be checked.
module tb_pingpong_lane_ram;

    localparam int N  = 32;
    localparam int WS = 16;
    localparam int L  = 2;
    localparam int AW = 5;
    localparam int SW = 2 * WS;

    logic clk = 1'b0;
    logic reset;
    logic swap_req;
    logic swap_ack, busy, fft_bank;

    logic [L*AW-1:0] io_wr_addr, io_rd_addr, fft_wr_addr, fft_rd_addr;
    logic [L*SW-1:0] io_wr_data, fft_wr_data, io_rd_data, fft_rd_data;
    logic [L-1:0]    io_wr_en, io_rd_en, fft_wr_en, fft_rd_en, io_rd_valid, fft_rd_valid;

    // side 0 = FFT, side 1 = IO
    logic [L-1:0]    wr_en_s [2];
    logic [L-1:0]    rd_en_s [2];
    logic [AW-1:0]   wr_addr_s [2][L];
    logic [AW-1:0]   rd_addr_s [2][L];
    logic [SW-1:0]   wr_data_s [2][L];

    // Reference: plain array of both banks plus current FFT-owned bank.
    logic [SW-1:0]   mdl [2][N];
    bit              mbank;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign fft_wr_en = wr_en_s[0];
    assign fft_rd_en = rd_en_s[0];
    assign io_wr_en  = wr_en_s[1];
    assign io_rd_en  = rd_en_s[1];
    for (genvar k = 0; k < L; k++) begin : g_flat
        assign fft_wr_addr[k*AW +: AW] = wr_addr_s[0][k];
        assign fft_rd_addr[k*AW +: AW] = rd_addr_s[0][k];
        assign fft_wr_data[k*SW +: SW] = wr_data_s[0][k];
        assign io_wr_addr[k*AW +: AW]  = wr_addr_s[1][k];
        assign io_rd_addr[k*AW +: AW]  = rd_addr_s[1][k];
        assign io_wr_data[k*SW +: SW]  = wr_data_s[1][k];
    end

    pingpong_lane_ram #(.N(N), .WORD_SIZE(WS), .LANES(L), .ADDR_W(AW)) dut (
        .clk          (clk),
        .reset        (reset),
        .swap_req     (swap_req),
        .swap_ack     (swap_ack),
        .busy         (busy),
        .fft_bank     (fft_bank),
        .io_wr_en     (io_wr_en),
        .io_wr_addr   (io_wr_addr),
        .io_wr_data   (io_wr_data),
        .io_rd_en     (io_rd_en),
        .io_rd_addr   (io_rd_addr),
        .io_rd_data   (io_rd_data),
        .io_rd_valid  (io_rd_valid),
        .fft_wr_en    (fft_wr_en),
        .fft_wr_addr  (fft_wr_addr),
        .fft_wr_data  (fft_wr_data),
        .fft_rd_en    (fft_rd_en),
        .fft_rd_addr  (fft_rd_addr),
        .fft_rd_data  (fft_rd_data),
        .fft_rd_valid (fft_rd_valid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [SW-1:0] obs_data(input int s, input int k);
        return (s == 0) ? fft_rd_data[k*SW +: SW] : io_rd_data[k*SW +: SW];
    endfunction

    function automatic logic obs_valid(input int s, input int k);
        return (s == 0) ? fft_rd_valid[k] : io_rd_valid[k];
    endfunction

    task automatic clear_inputs();
        swap_req = 1'b0;
        for (int s = 0; s < 2; s++) begin
            wr_en_s[s] = '0;
            rd_en_s[s] = '0;
            for (int k = 0; k < L; k++) begin
                wr_addr_s[s][k] = '0;
                rd_addr_s[s][k] = '0;
                wr_data_s[s][k] = '0;
            end
        end
    endtask

    task automatic rand_ops();
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < L; k++) begin
                wr_en_s[s][k]   = 1'($urandom_range(0, 1));
                rd_en_s[s][k]   = 1'($urandom_range(0, 1));
                wr_addr_s[s][k] = AW'($urandom_range(0, N - 1));
                rd_addr_s[s][k] = AW'($urandom_range(0, N - 1));
                wr_data_s[s][k] = $urandom();
            end
        end
    endtask

    // One clock with the inputs currently driven. 'accepted' says whether the DUT is in RUN
    // this cycle; if not, nothing may be read or written.
    task automatic tick(input bit accepted);
        logic [SW-1:0] exp_d [2][L];
        bit            exp_v [2][L];
        bit            bank;
        for (int s = 0; s < 2; s++) begin
            bank = (s == 0) ? mbank : !mbank;
            for (int k = 0; k < L; k++) begin
                exp_v[s][k] = accepted && rd_en_s[s][k];
                exp_d[s][k] = mdl[bank][rd_addr_s[s][k]];
`ifdef RAM_BYPASS_EN
                for (int j = 0; j < L; j++)
                    if (wr_en_s[s][j] && wr_addr_s[s][j] == rd_addr_s[s][k])
                        exp_d[s][k] = wr_data_s[s][j];
`endif
            end
        end
        if (accepted) begin
            for (int s = 0; s < 2; s++) begin
                bank = (s == 0) ? mbank : !mbank;
                for (int k = 0; k < L; k++)
                    if (wr_en_s[s][k]) mdl[bank][wr_addr_s[s][k]] = wr_data_s[s][k];
            end
        end
        @(posedge clk);
        #1;
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < L; k++) begin
                chk($sformatf("rd_valid s%0d l%0d", s, k), obs_valid(s, k), exp_v[s][k]);
                if (exp_v[s][k])
                    chk($sformatf("rd_data s%0d l%0d", s, k), obs_data(s, k), exp_d[s][k]);
            end
        end
        clear_inputs();
    endtask

    // Full swap with stray traffic and a repeated request while busy.
    task automatic do_swap();
        rand_ops();
        swap_req = 1'b1;
        tick(1);                         // request sampled; now in DRAIN
        chk("busy drain", busy, 1'b1);
        chk("ack drain", swap_ack, 1'b0);
        chk("bank drain", fft_bank, mbank);
        rand_ops();
        swap_req = 1'b1;
        tick(0);                         // now in SWAP
        chk("busy swap", busy, 1'b1);
        chk("ack swap", swap_ack, 1'b0);
        rand_ops();
        tick(0);                         // first RUN cycle after SWAP
        mbank = !mbank;
        chk("ack pulse", swap_ack, 1'b1);
        chk("bank after swap", fft_bank, mbank);
        chk("busy after swap", busy, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("no second ack", swap_ack, 1'b0);
            chk("busy idle", busy, 1'b0);
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < N; a += L) begin
            for (int s = 0; s < 2; s++)
                for (int k = 0; k < L; k++) begin
                    rd_en_s[s][k]   = 1'b1;
                    rd_addr_s[s][k] = AW'(a + k);
                end
            tick(1);
        end
    endtask

    initial begin
        clear_inputs();
        mbank = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset fft_bank", fft_bank, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset ack", swap_ack, 1'b0);
        chk("reset fft_valid", fft_rd_valid, '0);
        chk("reset io_valid", io_rd_valid, '0);
        chk("reset fft_data", fft_rd_data, '0);
        chk("reset io_data", io_rd_data, '0);
        reset = 1'b0;

        // Fill: FFT side loads bank 0 with a tag, IO side loads bank 1 with value = address.
        for (int a = 0; a < N; a += L) begin
            for (int k = 0; k < L; k++) begin
                wr_en_s[0][k] = 1'b1; wr_addr_s[0][k] = AW'(a + k); wr_data_s[0][k] = 32'hBEEF0000 + a + k;
                wr_en_s[1][k] = 1'b1; wr_addr_s[1][k] = AW'(a + k); wr_data_s[1][k] = SW'(a + k);
            end
            tick(1);
        end

        // Address 5 from both sides: FFT sees bank 0 tag, IO sees 5.
        rd_en_s[0][0] = 1'b1; rd_addr_s[0][0] = 5;
        rd_en_s[1][0] = 1'b1; rd_addr_s[1][0] = 5;
        tick(1);
        tick(1);                          // valid must drop again

        do_swap();

        // FFT now owns bank 1.
        rd_en_s[0][0] = 1'b1; rd_addr_s[0][0] = 7;
        tick(1);

        // Two IO lanes writing address 3: lane 1 must win.
        wr_en_s[1] = 2'b11;
        wr_addr_s[1][0] = 3; wr_data_s[1][0] = 32'hAAAA0000;
        wr_addr_s[1][1] = 3; wr_data_s[1][1] = 32'h55551111;
        tick(1);
        rd_en_s[1][1] = 1'b1; rd_addr_s[1][1] = 3;
        tick(1);

        // Same-cycle read and write of FFT address 9.
        rd_en_s[0][0] = 1'b1; rd_addr_s[0][0] = 9;
        wr_en_s[0][1] = 1'b1; wr_addr_s[0][1] = 9; wr_data_s[0][1] = 32'h00001234;
        tick(1);
        rd_en_s[0][0] = 1'b1; rd_addr_s[0][0] = 9;
        tick(1);

        repeat (150) begin
            rand_ops();
            tick(1);
        end
        do_swap();
        repeat (150) begin
            rand_ops();
            tick(1);
        end
        do_swap();                        // FFT owns bank 1 again
        read_all();

        // Reset asserted in the middle of the SWAP cycle.
        swap_req = 1'b1;
        tick(1);                          // DRAIN
        tick(0);                          // SWAP
        #2;
        reset = 1'b1;
        #1;
        chk("rst mid-swap bank", fft_bank, 1'b0);
        chk("rst mid-swap busy", busy, 1'b0);
        chk("rst mid-swap ack", swap_ack, 1'b0);
        mbank = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("no ack after reset", swap_ack, 1'b0);
        end
        read_all();                       // contents survive reset

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
